// File: rtl/vx_mem_perf_collector_pkg.sv
// Shared event indexing and sizing helpers for the memory performance collector.
// The event order sets the counter layout, so the readout index map depends on it.
package vx_mem_perf_collector_pkg;

  typedef enum logic [2:0] {
    PERF_EVT_READS      = 3'd0,
    PERF_EVT_WRITES     = 3'd1,
    PERF_EVT_READ_MISS  = 3'd2,
    PERF_EVT_WRITE_MISS = 3'd3,
    PERF_EVT_BANK_STALL = 3'd4,
    PERF_EVT_MSHR_STALL = 3'd5,
    PERF_EVT_CRSP_STALL = 3'd6
  } perf_evt_e;

  localparam int NUM_PERF_EVTS = 7;

  // Offsets of the memory-channel counters, placed after all per-source counters.
  localparam int PERF_MEM_RD_IDX  = 0;
  localparam int PERF_MEM_WR_IDX  = 1;
  localparam int PERF_MEM_LAT_IDX = 2;
  localparam int NUM_MEM_CTRS     = 3;

  function automatic int num_ctrs(input int num_srcs);
    return num_srcs * NUM_PERF_EVTS + NUM_MEM_CTRS;
  endfunction

  function automatic int sel_w(input int num_srcs);
    return $clog2(num_ctrs(num_srcs));
  endfunction

endpackage

// File: rtl/vx_mem_perf_collector_if.sv
// Control, event and readout signals between the memory hierarchy/CSR side and
// the perf collector; master drives events and selects, slave is the collector.
interface vx_mem_perf_collector_if
  import vx_mem_perf_collector_pkg::*;
#(
  parameter int NUM_SRCS = 5,
  parameter int EVT_W    = 4,
  parameter int CTR_W    = 44,
  parameter int OUTS_W   = 8
);
  localparam int SEL_W = sel_w(NUM_SRCS);

  logic                                   enable;
  logic                                   clear;
  logic                                   snap_req;
  logic                                   snap_ack;
  logic [NUM_SRCS*NUM_PERF_EVTS*EVT_W-1:0] src_evt;
  logic                                   mem_req_fire;
  logic                                   mem_req_rw;
  logic                                   mem_rsp_fire;
  logic [SEL_W-1:0]                       rd_sel;
  logic [CTR_W-1:0]                       rd_data;
  logic [OUTS_W-1:0]                      outstanding;
  logic                                   err_underflow;

  modport master (
    output enable, clear, snap_req, src_evt, mem_req_fire, mem_req_rw, mem_rsp_fire, rd_sel,
    input  snap_ack, rd_data, outstanding, err_underflow
  );

  modport slave (
    input  enable, clear, snap_req, src_evt, mem_req_fire, mem_req_rw, mem_rsp_fire, rd_sel,
    output snap_ack, rd_data, outstanding, err_underflow
  );
endinterface

// File: rtl/vx_mem_perf_collector_ctr.sv
// Single live performance counter: accumulates a zero-extended increment when
// enabled, synchronous clear wins, optional saturation at all-ones.
module vx_mem_perf_collector_ctr #(
  parameter int CTR_W    = 44,
  parameter int INC_W    = 4,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [CTR_W-1:0] value_o
);

  logic [CTR_W-1:0] value_q, value_d;
  logic [CTR_W:0]   sum;

  // NOTE: every signal assigned here gets a value before any branch, so no latch is inferred.
  always_comb begin
    sum     = {1'b0, value_q} + (CTR_W+1)'(inc_i);
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (en_i) begin
      value_d = (SATURATE != 0 && sum[CTR_W]) ? '1 : sum[CTR_W-1:0];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/vx_mem_perf_collector.sv
// Memory-hierarchy perf collector: per-source event counters, memory read/write
// counts, outstanding-read latency accumulation, shadow snapshot and registered readout.
module vx_mem_perf_collector
  import vx_mem_perf_collector_pkg::*;
#(
  parameter int NUM_SRCS = 5,
  parameter int EVT_W    = 4,
  parameter int CTR_W    = 44,
  parameter int OUTS_W   = 8,
  parameter int SATURATE = 1
) (
  input logic                    clk,
  input logic                    rst,
  vx_mem_perf_collector_if.slave bus
);

  localparam int N_CTR    = num_ctrs(NUM_SRCS);
  localparam int MEM_BASE = NUM_SRCS * NUM_PERF_EVTS;

  logic [CTR_W-1:0]  live     [N_CTR];
  logic [CTR_W-1:0]  shadow_q [N_CTR];
  logic [CTR_W-1:0]  shadow_d [N_CTR];
  logic [CTR_W-1:0]  rd_data_q, rd_data_d;
  logic [OUTS_W-1:0] outstanding_q, outstanding_d;
  logic              err_q, err_d;
  logic              snap_ack_q;
  logic              rd_fire, wr_fire;

  assign rd_fire = bus.mem_req_fire & ~bus.mem_req_rw;
  assign wr_fire = bus.mem_req_fire &  bus.mem_req_rw;

  for (genvar s = 0; s < NUM_SRCS; s++) begin : g_src
    for (genvar e = 0; e < NUM_PERF_EVTS; e++) begin : g_evt
      vx_mem_perf_collector_ctr #(
        .CTR_W(CTR_W), .INC_W(EVT_W), .SATURATE(SATURATE)
      ) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .en_i    (bus.enable),
        .clr_i   (bus.clear),
        .inc_i   (bus.src_evt[(s*NUM_PERF_EVTS+e)*EVT_W +: EVT_W]),
        .value_o (live[s*NUM_PERF_EVTS+e])
      );
    end
  end

  vx_mem_perf_collector_ctr #(.CTR_W(CTR_W), .INC_W(1), .SATURATE(SATURATE)) u_mem_rd (
    .clk(clk), .rst(rst), .en_i(bus.enable), .clr_i(bus.clear),
    .inc_i(rd_fire), .value_o(live[MEM_BASE+PERF_MEM_RD_IDX])
  );

  vx_mem_perf_collector_ctr #(.CTR_W(CTR_W), .INC_W(1), .SATURATE(SATURATE)) u_mem_wr (
    .clk(clk), .rst(rst), .en_i(bus.enable), .clr_i(bus.clear),
    .inc_i(wr_fire), .value_o(live[MEM_BASE+PERF_MEM_WR_IDX])
  );

  // Latency integrates the registered outstanding count, one cycle per pending read.
  vx_mem_perf_collector_ctr #(.CTR_W(CTR_W), .INC_W(OUTS_W), .SATURATE(SATURATE)) u_mem_lat (
    .clk(clk), .rst(rst), .en_i(bus.enable), .clr_i(bus.clear),
    .inc_i(outstanding_q), .value_o(live[MEM_BASE+PERF_MEM_LAT_IDX])
  );

  always_comb begin
    outstanding_d = outstanding_q;
    err_d         = err_q;
    if (bus.clear) begin
      outstanding_d = '0;
      err_d         = 1'b0;
    end else if (bus.enable) begin
      unique case ({rd_fire, bus.mem_rsp_fire})
        2'b10: if (outstanding_q != '1) outstanding_d = outstanding_q + OUTS_W'(1);
        2'b01: begin
          if (outstanding_q == '0) err_d = 1'b1;
          else                     outstanding_d = outstanding_q - OUTS_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Readout selects from the post-capture shadow so a same-cycle snapshot is never missed.
  always_comb begin
    shadow_d = shadow_q;
    if (bus.snap_req) shadow_d = live;
    rd_data_d = '0;
    if (int'(bus.rd_sel) < N_CTR) rd_data_d = shadow_d[bus.rd_sel];
  end

  // NOTE: the shadow bank is architecturally visible after reset, so it is built from resettable flops, not RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q      <= '{default: '0};
      rd_data_q     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      snap_ack_q    <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      rd_data_q     <= rd_data_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      snap_ack_q    <= bus.snap_req;
    end
  end

  assign bus.rd_data       = rd_data_q;
  assign bus.outstanding   = outstanding_q;
  assign bus.err_underflow = err_q;
  assign bus.snap_ack      = snap_ack_q;

endmodule

// File: tb/tb_vx_mem_perf_collector.sv
// Directed bench: a default 44-bit collector plus 8-bit saturating and wrapping
// instances, all driven by the same stimulus.
module tb_vx_mem_perf_collector;
  import vx_mem_perf_collector_pkg::*;

  localparam int NUM_SRCS = 5;
  localparam int EVT_W    = 4;
  localparam int OUTS_W   = 8;
  localparam int SEL_W    = sel_w(NUM_SRCS);
  localparam int EVT_VW   = NUM_SRCS * NUM_PERF_EVTS * EVT_W;
  localparam int MEM_BASE = NUM_SRCS * NUM_PERF_EVTS;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic              snap_req = 1'b0;
  logic [EVT_VW-1:0] src_evt = '0;
  logic              mem_req_fire = 1'b0;
  logic              mem_req_rw = 1'b0;
  logic              mem_rsp_fire = 1'b0;
  logic [SEL_W-1:0]  rd_sel = '0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  vx_mem_perf_collector_if #(.NUM_SRCS(NUM_SRCS), .EVT_W(EVT_W), .CTR_W(44), .OUTS_W(OUTS_W)) if_main ();
  vx_mem_perf_collector_if #(.NUM_SRCS(NUM_SRCS), .EVT_W(EVT_W), .CTR_W(8),  .OUTS_W(OUTS_W)) if_s8 ();
  vx_mem_perf_collector_if #(.NUM_SRCS(NUM_SRCS), .EVT_W(EVT_W), .CTR_W(8),  .OUTS_W(OUTS_W)) if_w8 ();

  assign if_main.enable = enable;       assign if_s8.enable = enable;       assign if_w8.enable = enable;
  assign if_main.clear = clear;         assign if_s8.clear = clear;         assign if_w8.clear = clear;
  assign if_main.snap_req = snap_req;   assign if_s8.snap_req = snap_req;   assign if_w8.snap_req = snap_req;
  assign if_main.src_evt = src_evt;     assign if_s8.src_evt = src_evt;     assign if_w8.src_evt = src_evt;
  assign if_main.mem_req_fire = mem_req_fire; assign if_s8.mem_req_fire = mem_req_fire; assign if_w8.mem_req_fire = mem_req_fire;
  assign if_main.mem_req_rw = mem_req_rw;     assign if_s8.mem_req_rw = mem_req_rw;     assign if_w8.mem_req_rw = mem_req_rw;
  assign if_main.mem_rsp_fire = mem_rsp_fire; assign if_s8.mem_rsp_fire = mem_rsp_fire; assign if_w8.mem_rsp_fire = mem_rsp_fire;
  assign if_main.rd_sel = rd_sel;       assign if_s8.rd_sel = rd_sel;       assign if_w8.rd_sel = rd_sel;

  vx_mem_perf_collector #(.NUM_SRCS(NUM_SRCS), .EVT_W(EVT_W), .CTR_W(44), .OUTS_W(OUTS_W), .SATURATE(1))
    dut (.clk(clk), .rst(rst), .bus(if_main));
  vx_mem_perf_collector #(.NUM_SRCS(NUM_SRCS), .EVT_W(EVT_W), .CTR_W(8), .OUTS_W(OUTS_W), .SATURATE(1))
    dut_s8 (.clk(clk), .rst(rst), .bus(if_s8));
  vx_mem_perf_collector #(.NUM_SRCS(NUM_SRCS), .EVT_W(EVT_W), .CTR_W(8), .OUTS_W(OUTS_W), .SATURATE(0))
    dut_w8 (.clk(clk), .rst(rst), .bus(if_w8));

  function automatic logic [EVT_VW-1:0] evt(input int s, input int e, input int val);
    logic [EVT_VW-1:0] v;
    v = '0;
    v[(s*NUM_PERF_EVTS+e)*EVT_W +: EVT_W] = EVT_W'(val);
    return v;
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic snapshot(output logic ack);
    snap_req = 1'b1;
    tick();
    ack = if_main.snap_ack;
    snap_req = 1'b0;
  endtask

  task automatic read_ctr(input int idx, output logic [43:0] m, output logic [7:0] s8, output logic [7:0] w8);
    rd_sel = SEL_W'(idx);
    tick();
    m  = if_main.rd_data;
    s8 = if_s8.rd_data;
    w8 = if_w8.rd_data;
  endtask

  task automatic test_reset();
    total_cnt++; if (if_main.rd_data !== 44'd0) $display("FAIL reset_rd_data got %0d want 0", if_main.rd_data); else pass_cnt++;
    total_cnt++; if (if_main.outstanding !== 8'd0) $display("FAIL reset_outstanding got %0d want 0", if_main.outstanding); else pass_cnt++;
    total_cnt++; if (if_main.snap_ack !== 1'b0) $display("FAIL reset_snap_ack got %0b want 0", if_main.snap_ack); else pass_cnt++;
    total_cnt++; if (if_main.err_underflow !== 1'b0) $display("FAIL reset_err got %0b want 0", if_main.err_underflow); else pass_cnt++;
  endtask

  task automatic test_reset_mid_count();
    logic [43:0] m; logic [7:0] a, b; logic ack;
    enable = 1'b1;
    src_evt = evt(1, PERF_EVT_READS, 1);
    repeat (10) tick();
    src_evt = '0;
    mem_req_fire = 1'b1;
    tick();
    mem_req_fire = 1'b0;
    snapshot(ack);
    read_ctr(1*NUM_PERF_EVTS + 0, m, a, b);
    total_cnt++; if (m !== 44'd10) $display("FAIL midcnt_src1_reads got %0d want 10", m); else pass_cnt++;
    total_cnt++; if (if_main.outstanding !== 8'd1) $display("FAIL midcnt_outstanding got %0d want 1", if_main.outstanding); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (if_main.rd_data !== 44'd0) $display("FAIL async_rst_rd_data got %0d want 0", if_main.rd_data); else pass_cnt++;
    total_cnt++; if (if_main.outstanding !== 8'd0) $display("FAIL async_rst_outstanding got %0d want 0", if_main.outstanding); else pass_cnt++;
    total_cnt++; if (if_main.err_underflow !== 1'b0) $display("FAIL async_rst_err got %0b want 0", if_main.err_underflow); else pass_cnt++;
    #3 rst = 1'b0;
    tick();
    snapshot(ack);
    read_ctr(1*NUM_PERF_EVTS + 0, m, a, b);
    total_cnt++; if (m !== 44'd0) $display("FAIL post_rst_src1_reads got %0d want 0", m); else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic [43:0] m; logic [7:0] a, b; logic ack;
    do_clear();
    src_evt = evt(0, PERF_EVT_READS, 15);
    repeat (20) tick();
    src_evt = '0;
    snapshot(ack);
    read_ctr(0, m, a, b);
    total_cnt++; if (m !== 44'd300) $display("FAIL sat_main got %0d want 300", m); else pass_cnt++;
    total_cnt++; if (a !== 8'd255) $display("FAIL sat_ctr8 got %0d want 255", a); else pass_cnt++;
    total_cnt++; if (b !== 8'd44) $display("FAIL wrap_ctr8 got %0d want 44", b); else pass_cnt++;
  endtask

  task automatic test_tracker_latency();
    logic [43:0] m; logic [7:0] a, b; logic ack;
    do_clear();
    for (int c = 0; c < 8; c++) begin
      mem_req_fire = (c <= 3);
      mem_req_rw   = (c == 3);
      mem_rsp_fire = (c >= 5);
      tick();
      if (c == 2) begin
        total_cnt++; if (if_main.outstanding !== 8'd3) $display("FAIL trk_peak got %0d want 3", if_main.outstanding); else pass_cnt++;
      end
    end
    mem_req_fire = 1'b0; mem_req_rw = 1'b0; mem_rsp_fire = 1'b0;
    total_cnt++; if (if_main.outstanding !== 8'd0) $display("FAIL trk_drain got %0d want 0", if_main.outstanding); else pass_cnt++;
    tick();
    snapshot(ack);
    read_ctr(MEM_BASE + PERF_MEM_RD_IDX, m, a, b);
    total_cnt++; if (m !== 44'd3) $display("FAIL mem_reads got %0d want 3", m); else pass_cnt++;
    read_ctr(MEM_BASE + PERF_MEM_WR_IDX, m, a, b);
    total_cnt++; if (m !== 44'd1) $display("FAIL mem_writes got %0d want 1", m); else pass_cnt++;
    read_ctr(MEM_BASE + PERF_MEM_LAT_IDX, m, a, b);
    total_cnt++; if (m !== 44'd15) $display("FAIL mem_latency got %0d want 15", m); else pass_cnt++;
    total_cnt++; if (a !== 8'd15) $display("FAIL mem_latency_ctr8 got %0d want 15", a); else pass_cnt++;
    total_cnt++; if (if_main.err_underflow !== 1'b0) $display("FAIL trk_no_err got %0b want 0", if_main.err_underflow); else pass_cnt++;
  endtask

  task automatic test_underflow();
    do_clear();
    mem_rsp_fire = 1'b1;
    tick();
    mem_rsp_fire = 1'b0;
    total_cnt++; if (if_main.outstanding !== 8'd0) $display("FAIL uflow_outstanding got %0d want 0", if_main.outstanding); else pass_cnt++;
    total_cnt++; if (if_main.err_underflow !== 1'b1) $display("FAIL uflow_err got %0b want 1", if_main.err_underflow); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (if_main.err_underflow !== 1'b1) $display("FAIL uflow_sticky got %0b want 1", if_main.err_underflow); else pass_cnt++;
    do_clear();
    total_cnt++; if (if_main.err_underflow !== 1'b0) $display("FAIL uflow_cleared got %0b want 0", if_main.err_underflow); else pass_cnt++;
    mem_req_fire = 1'b1; mem_rsp_fire = 1'b1;
    tick();
    mem_req_fire = 1'b0; mem_rsp_fire = 1'b0;
    total_cnt++; if (if_main.outstanding !== 8'd0) $display("FAIL req_rsp_zero_outs got %0d want 0", if_main.outstanding); else pass_cnt++;
    total_cnt++; if (if_main.err_underflow !== 1'b0) $display("FAIL req_rsp_zero_err got %0b want 0", if_main.err_underflow); else pass_cnt++;
    mem_req_fire = 1'b1;
    repeat (260) tick();
    mem_req_fire = 1'b0;
    total_cnt++; if (if_main.outstanding !== 8'd255) $display("FAIL outs_sat got %0d want 255", if_main.outstanding); else pass_cnt++;
    mem_rsp_fire = 1'b1;
    tick();
    mem_rsp_fire = 1'b0;
    total_cnt++; if (if_main.outstanding !== 8'd254) $display("FAIL outs_dec got %0d want 254", if_main.outstanding); else pass_cnt++;
    do_clear();
    total_cnt++; if (if_main.outstanding !== 8'd0) $display("FAIL outs_clear got %0d want 0", if_main.outstanding); else pass_cnt++;
  endtask

  task automatic test_clear_snap();
    logic [43:0] m; logic [7:0] a, b; logic ack;
    do_clear();
    src_evt = evt(1, PERF_EVT_WRITE_MISS, 7);
    tick();
    src_evt = '0;
    clear = 1'b1;
    snap_req = 1'b1;
    tick();
    clear = 1'b0;
    snap_req = 1'b0;
    total_cnt++; if (if_main.snap_ack !== 1'b1) $display("FAIL clrsnap_ack got %0b want 1", if_main.snap_ack); else pass_cnt++;
    read_ctr(1*NUM_PERF_EVTS + 3, m, a, b);
    total_cnt++; if (m !== 44'd7) $display("FAIL clrsnap_shadow got %0d want 7", m); else pass_cnt++;
    total_cnt++; if (if_main.snap_ack !== 1'b0) $display("FAIL clrsnap_ack_pulse got %0b want 0", if_main.snap_ack); else pass_cnt++;
    snapshot(ack);
    read_ctr(1*NUM_PERF_EVTS + 3, m, a, b);
    total_cnt++; if (m !== 44'd0) $display("FAIL clrsnap_live got %0d want 0", m); else pass_cnt++;
  endtask

  task automatic test_enable_gating();
    logic [43:0] m; logic [7:0] a, b; logic ack;
    do_clear();
    src_evt = evt(2, PERF_EVT_READS, 2);
    repeat (3) tick();
    enable = 1'b0;
    for (int i = 0; i < NUM_SRCS*NUM_PERF_EVTS; i++) src_evt[i*EVT_W +: EVT_W] = EVT_W'(3);
    mem_req_fire = 1'b1;
    repeat (10) tick();
    src_evt = '0;
    mem_req_fire = 1'b0;
    total_cnt++; if (if_main.outstanding !== 8'd0) $display("FAIL gate_outstanding got %0d want 0", if_main.outstanding); else pass_cnt++;
    snapshot(ack);
    total_cnt++; if (ack !== 1'b1) $display("FAIL gate_snap_ack got %0b want 1", ack); else pass_cnt++;
    read_ctr(2*NUM_PERF_EVTS + 0, m, a, b);
    total_cnt++; if (m !== 44'd6) $display("FAIL gate_src2_reads got %0d want 6", m); else pass_cnt++;
    read_ctr(0, m, a, b);
    total_cnt++; if (m !== 44'd0) $display("FAIL gate_src0_reads got %0d want 0", m); else pass_cnt++;
    read_ctr(MEM_BASE + PERF_MEM_RD_IDX, m, a, b);
    total_cnt++; if (m !== 44'd0) $display("FAIL gate_mem_reads got %0d want 0", m); else pass_cnt++;
    enable = 1'b1;
  endtask

  task automatic test_out_of_range();
    logic [43:0] m; logic [7:0] a, b;
    read_ctr(2*NUM_PERF_EVTS + 0, m, a, b);
    total_cnt++; if (m !== 44'd6) $display("FAIL oor_inrange got %0d want 6", m); else pass_cnt++;
    read_ctr(MEM_BASE + NUM_MEM_CTRS, m, a, b);
    total_cnt++; if (m !== 44'd0) $display("FAIL oor_first got %0d want 0", m); else pass_cnt++;
    read_ctr((1 << SEL_W) - 1, m, a, b);
    total_cnt++; if (m !== 44'd0) $display("FAIL oor_max got %0d want 0", m); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [43:0] m; logic [7:0] a, b;
    do_clear();
    src_evt = evt(0, PERF_EVT_READS, 1);
    repeat (5) tick();
    snap_req = 1'b1;
    tick();
    total_cnt++; if (if_main.snap_ack !== 1'b1) $display("FAIL b2b_ack1 got %0b want 1", if_main.snap_ack); else pass_cnt++;
    tick();
    total_cnt++; if (if_main.snap_ack !== 1'b1) $display("FAIL b2b_ack2 got %0b want 1", if_main.snap_ack); else pass_cnt++;
    snap_req = 1'b0;
    src_evt = '0;
    tick();
    total_cnt++; if (if_main.snap_ack !== 1'b0) $display("FAIL b2b_ack_end got %0b want 0", if_main.snap_ack); else pass_cnt++;
    read_ctr(0, m, a, b);
    total_cnt++; if (m !== 44'd6) $display("FAIL b2b_second_capture got %0d want 6", m); else pass_cnt++;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    #4 rst = 1'b0;
    tick();
    test_reset_mid_count();
    test_saturation();
    test_tracker_latency();
    test_underflow();
    test_clear_snap();
    test_enable_gating();
    test_out_of_range();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
